pwm4_compare: RTL and testbench



---
 rtl/pwm4_compare_if.sv | 35 +++
 rtl/pwm4_compare.sv | 87 ++++++++
 tb/tb_pwm4_compare.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pwm4_compare_if.sv
// pwm4_compare_if
//   Groups the PWM control and status signals that cross between the
//   block and its user. The clock and reset stay outside the interface.
//
//   CE      count enable (counter, O and duty/period transfer advance)
//   DUTY    new duty threshold, captured into the shadow register on LOAD
//   PERIOD  new terminal count, captured into the shadow register on LOAD
//   LOAD    write DUTY/PERIOD into the shadow registers
//   O       registered PWM output
//   WRAP    one-cycle pulse after the counter wraps
//   PENDING shadow registers hold values not yet transferred
//
//   Modports: master drives the controls (the user of the block);
//             slave is the pwm4_compare side.
interface pwm4_compare_if #(
  parameter int WIDTH = 4
);
  logic             CE;
  logic [WIDTH-1:0] DUTY;
  logic [WIDTH-1:0] PERIOD;
  logic             LOAD;
  logic             O;
  logic             WRAP;
  logic             PENDING;

  modport master (
    output CE, DUTY, PERIOD, LOAD,
    input  O, WRAP, PENDING
  );

  modport slave (
    input  CE, DUTY, PERIOD, LOAD,
    output O, WRAP, PENDING
  );
endinterface

// File: rtl/pwm4_compare.sv
// pwm4_compare
//   PWM generator built around an unsigned WIDTH-bit compare taken from the
//   borrow-out of a subtractor. A free-running counter runs 0..act_period
//   and O is high while count < act_duty. Duty and period are written to
//   shadow registers by LOAD and copied into the active registers only at
//   a period boundary, so a period is never cut short or stretched.
//
//   Ports
//     CLK    clock, rising edge
//     RESET  synchronous, active-high; overrides everything, discards
//            any pending load
//     bus    pwm4_compare_if.slave: CE, DUTY, PERIOD, LOAD in;
//            O, WRAP, PENDING out
module pwm4_compare #(
  parameter int WIDTH = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  pwm4_compare_if.slave bus
);

  // Borrow-out of a - b: set exactly when a < b (unsigned), i.e. NOT UGE.
  function automatic logic lt_borrow(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    logic [WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[WIDTH];
  endfunction

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_act_duty;
  logic [WIDTH-1:0] r_act_period;
  logic [WIDTH-1:0] r_shd_duty;
  logic [WIDTH-1:0] r_shd_period;
  logic             r_pending;
  logic             r_o;
  logic             r_wrap;

  logic             w_at_term;
  logic             w_lt;
  logic             w_xfer;

  assign w_at_term = (r_count == r_act_period);
  assign w_lt      = lt_borrow(r_count, r_act_duty);
  // Transfer reads the shadow contents from before this edge, so a LOAD
  // in the same cycle lands in shadow and waits for the next wrap.
  assign w_xfer    = bus.CE && w_at_term && r_pending;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count      <= '0;
      r_act_duty   <= '0;
      r_act_period <= '1;
      r_shd_duty   <= '0;
      r_shd_period <= '0;
      r_pending    <= 1'b0;
      r_o          <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      // WRAP is a single-cycle pulse; it drops on any non-wrapping edge,
      // including CE=0 edges.
      r_wrap <= bus.CE && w_at_term;

      if (bus.CE) begin
        r_count <= w_at_term ? '0 : r_count + WIDTH'(1);
        r_o     <= w_lt;
        if (w_xfer) begin
          r_act_duty   <= r_shd_duty;
          r_act_period <= r_shd_period;
        end
      end

      if (bus.LOAD) begin
        r_shd_duty   <= bus.DUTY;
        r_shd_period <= bus.PERIOD;
        r_pending    <= 1'b1;
      end else if (w_xfer) begin
        r_pending    <= 1'b0;
      end
    end
  end

  assign bus.O       = r_o;
  assign bus.WRAP    = r_wrap;
  assign bus.PENDING = r_pending;

endmodule

// File: tb/tb_pwm4_compare.sv
module tb_pwm4_compare;

  localparam int W = 4;

  logic CLK;
  logic RESET;

  pwm4_compare_if #(.WIDTH(W)) bus ();

  pwm4_compare #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic o;
    logic wrap;
    logic pend;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycno = 0;

  // Reference model: plain integers describing the spec's rules.
  int m_cnt, m_ad, m_ap, m_sd, m_sp;
  bit m_pend, m_o, m_wrap;

  task automatic model_step(input bit rst, input bit ce, input bit ld,
                            input int d, input int p);
    bit at_end, xfer;
    if (rst) begin
      m_cnt = 0; m_ad = 0; m_ap = (1 << W) - 1; m_sd = 0; m_sp = 0;
      m_pend = 0; m_o = 0; m_wrap = 0;
      return;
    end
    at_end = (m_cnt == m_ap);
    xfer   = ce && at_end && m_pend;
    m_wrap = ce && at_end;
    if (ce) begin
      m_o   = (m_cnt < m_ad);
      m_cnt = at_end ? 0 : m_cnt + 1;
      if (xfer) begin
        m_ad = m_sd;
        m_ap = m_sp;
      end
    end
    if (ld) begin
      m_sd = d; m_sp = p; m_pend = 1;
    end else if (xfer) begin
      m_pend = 0;
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected after
  // the following rising edge.
  task automatic cyc(input bit rst, input bit ce, input bit ld,
                     input int d, input int p);
    exp_t e;
    @(negedge CLK);
    RESET      = rst;
    bus.CE     = ce;
    bus.LOAD   = ld;
    bus.DUTY   = W'(d);
    bus.PERIOD = W'(p);
    model_step(rst, ce, ld, d, p);
    cycno++;
    e.o = m_o; e.wrap = m_wrap; e.pend = m_pend; e.cyc = cycno;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit ce);
    for (int i = 0; i < n; i++) cyc(0, ce, 0, 0, 0);
  endtask

  // Monitor: the DUT presents O/WRAP/PENDING every cycle.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (bus.O !== e.o) begin
        bad++;
        $display("FAIL O cyc=%0d got=%b want=%b", e.cyc, bus.O, e.o);
      end
      total++;
      if (bus.WRAP !== e.wrap) begin
        bad++;
        $display("FAIL WRAP cyc=%0d got=%b want=%b", e.cyc, bus.WRAP, e.wrap);
      end
      total++;
      if (bus.PENDING !== e.pend) begin
        bad++;
        $display("FAIL PENDING cyc=%0d got=%b want=%b", e.cyc, bus.PENDING, e.pend);
      end
    end
  end

  initial begin
    RESET = 1'b1; bus.CE = 1'b0; bus.LOAD = 1'b0;
    bus.DUTY = '0; bus.PERIOD = '0;

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 5, 5);

    // Free-run with reset values: duty 0, period 15
    run(20, 1);

    // Re-sync at reset, then LOAD (2,3) when count=5
    cyc(1, 0, 0, 0, 0);
    run(5, 1);
    cyc(0, 1, 1, 2, 3);
    run(20, 1);

    // With (2,3) active, LOAD (4,3): duty > period
    cyc(0, 1, 1, 4, 3);
    run(12, 1);

    // LOAD (1,3), then LOAD (3,7) exactly on the wrap cycle
    cyc(0, 1, 1, 1, 3);
    while (m_cnt != m_ap) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 3, 7);
    run(20, 1);

    // CE patterns with period 3
    cyc(0, 1, 1, 2, 3);
    while (m_pend) cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    end
    // CE dropped right after a wrapping cycle
    while (m_cnt != m_ap) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    // LOAD with CE low still writes shadow
    cyc(0, 0, 1, 6, 9);
    run(15, 1);

    // PERIOD=0, DUTY=1, then RESET mid-run with a pending load
    cyc(0, 1, 1, 1, 0);
    run(16, 1);
    cyc(0, 1, 1, 7, 7);
    cyc(1, 1, 0, 0, 0);
    run(20, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit rst, ce, ld;
      int d, p;
      rst = ($urandom_range(0, 199) == 0);
      ce  = ($urandom_range(0, 9) < 8);
      ld  = ($urandom_range(0, 15) == 0);
      p   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      d   = $urandom_range(0, 15);
      cyc(rst, ce, ld, d, p);
    end

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge CLK);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
